// File: rtl/pc_unit.sv
// Program counter with optional return-address stack (enable with `define PC_UNIT_RAS_EN).
// Without the macro, Push is ignored, a pop select holds the PC and the stack flags are constant.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(16'h0200),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_PC,
  input  logic [1:0]       PCMUX,
  input  logic             Push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [WIDTH-1:0] AdderOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             RAS_Empty,
  output logic             RAS_Full,
  output logic             RAS_Err
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc  = pc + WIDTH'(1);
  assign dataOut = pc;

`ifdef PC_UNIT_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH + 1);

  // stk[0] is the top of stack; pushes shift toward the bottom so the oldest entry falls off.
  logic [WIDTH-1:0] stk [RAS_DEPTH];
  logic [CW-1:0]    count;
  logic             err;
  logic             is_pop;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign is_pop  = (PCMUX == 2'b11);
  assign full    = (count == CW'(RAS_DEPTH));
  assign do_push = LD_PC && Push && !is_pop;
  assign do_pop  = LD_PC && is_pop && (count != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc    <= RESET_VEC;
      count <= '0;
      err   <= 1'b0;
    end else if (LD_PC) begin
      case (PCMUX)
        2'b00: pc <= pc_inc;
        2'b01: pc <= AdderOut;
        2'b10: pc <= dataIn;
        default: begin
          if (count != '0) begin
            pc    <= stk[0];
            count <= count - CW'(1);
          end else begin
            err <= 1'b1;
          end
        end
      endcase
      if (do_push) begin
        if (full) err <= 1'b1;
        else      count <= count + CW'(1);
      end
    end
  end

  // Stack storage carries no reset; only the count defines which entries are valid.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (do_push) begin
        stk[0] <= pc_inc;
        for (int i = 1; i < RAS_DEPTH; i++) stk[i] <= stk[i-1];
      end else if (do_pop) begin
        for (int i = 0; i < RAS_DEPTH - 1; i++) stk[i] <= stk[i+1];
      end
    end
  end

  assign RAS_Empty = (count == '0);
  assign RAS_Full  = full;
  assign RAS_Err   = err;
`else
  logic unused_push;
  assign unused_push = Push;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= RESET_VEC;
    end else if (LD_PC) begin
      case (PCMUX)
        2'b00:   pc <= pc_inc;
        2'b01:   pc <= AdderOut;
        2'b10:   pc <= dataIn;
        default: pc <= pc;
      endcase
    end
  end

  assign RAS_Empty = 1'b1;
  assign RAS_Full  = 1'b0;
  assign RAS_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: increment/wrap/load paths, plus stack push/pop/overflow/underflow
// and reset dominance when built with PC_UNIT_RAS_EN.
module tb_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        LD_PC = 1'b0;
  logic [1:0]  PCMUX = 2'b00;
  logic        Push = 1'b0;
  logic [15:0] dataIn = '0;
  logic [15:0] AdderOut = '0;
  logic [15:0] dataOut;
  logic        RAS_Empty;
  logic        RAS_Full;
  logic        RAS_Err;

  int total = 0;
  int bad   = 0;

  pc_unit #(.WIDTH(16), .RESET_VEC(16'h0200), .RAS_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .LD_PC(LD_PC), .PCMUX(PCMUX), .Push(Push),
    .dataIn(dataIn), .AdderOut(AdderOut), .dataOut(dataOut),
    .RAS_Empty(RAS_Empty), .RAS_Full(RAS_Full), .RAS_Err(RAS_Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f, input logic r);
    check({tag, "_empty"}, {15'd0, RAS_Empty}, {15'd0, e});
    check({tag, "_full"},  {15'd0, RAS_Full},  {15'd0, f});
    check({tag, "_err"},   {15'd0, RAS_Err},   {15'd0, r});
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic ld, input logic [1:0] mux, input logic push,
                      input logic [15:0] din, input logic [15:0] add);
    @(negedge Clk);
    LD_PC = ld; PCMUX = mux; Push = push; dataIn = din; AdderOut = add;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Reset = 1'b0; LD_PC = 1'b0; Push = 1'b0; PCMUX = 2'b00;
  endtask

  initial begin
    do_reset();
    check("reset_pc", dataOut, 16'h0200);
    check_flags("reset", 1'b1, 1'b0, 1'b0);

    step(1, 2'b00, 0, 16'h0, 16'h0); check("inc1", dataOut, 16'h0201);
    step(1, 2'b00, 0, 16'h0, 16'h0); check("inc2", dataOut, 16'h0202);
    step(1, 2'b00, 0, 16'h0, 16'h0); check("inc3", dataOut, 16'h0203);

    step(1, 2'b10, 0, 16'hFFFF, 16'h0); check("load_ffff", dataOut, 16'hFFFF);
    step(1, 2'b00, 0, 16'h0, 16'h0);    check("wrap", dataOut, 16'h0000);
    step(1, 2'b01, 0, 16'h0, 16'h1234); check("adder", dataOut, 16'h1234);
    step(1, 2'b10, 0, 16'hBEEF, 16'h0); check("datain", dataOut, 16'hBEEF);
    step(0, 2'b01, 1, 16'h0, 16'h7777); check("hold_ld0", dataOut, 16'hBEEF);

`ifdef PC_UNIT_RAS_EN
    step(1, 2'b10, 0, 16'h3000, 16'h0); check("ld3000", dataOut, 16'h3000);
    step(1, 2'b01, 1, 16'h0, 16'h4000); check("call", dataOut, 16'h4000);
    check_flags("call", 1'b0, 1'b0, 1'b0);
    step(1, 2'b00, 0, 16'h0, 16'h0);    check("callee_inc", dataOut, 16'h4001);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("ret", dataOut, 16'h3001);
    check_flags("ret", 1'b1, 1'b0, 1'b0);

    // Five pushes into a 4-deep stack: 3002 is discarded.
    step(1, 2'b10, 1, 16'h1000, 16'h0); check("p1", dataOut, 16'h1000);
    step(1, 2'b10, 1, 16'h2000, 16'h0); check("p2", dataOut, 16'h2000);
    step(1, 2'b10, 1, 16'h3000, 16'h0); check("p3", dataOut, 16'h3000);
    step(1, 2'b10, 1, 16'h4000, 16'h0); check_flags("p4", 1'b0, 1'b1, 1'b0);
    step(1, 2'b10, 1, 16'h5000, 16'h0); check_flags("p5", 1'b0, 1'b1, 1'b1);
    step(1, 2'b11, 1, 16'h0, 16'h0);    check("pop1", dataOut, 16'h4001);
    check_flags("pop1", 1'b0, 1'b0, 1'b1);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("pop2", dataOut, 16'h3001);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("pop3", dataOut, 16'h2001);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("pop4", dataOut, 16'h1001);
    check_flags("pop4", 1'b1, 1'b0, 1'b1);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("pop5_hold", dataOut, 16'h1001);
    check_flags("pop5", 1'b1, 1'b0, 1'b1);

    do_reset();
    check("reset2", dataOut, 16'h0200);
    check_flags("reset2", 1'b1, 1'b0, 1'b0);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("underflow_hold", dataOut, 16'h0200);
    check_flags("underflow", 1'b1, 1'b0, 1'b1);

    do_reset();
    step(1, 2'b00, 1, 16'h0, 16'h0);    check("push_inc", dataOut, 16'h0201);
    step(0, 2'b11, 1, 16'h0, 16'h0);    check("ld0_nopop", dataOut, 16'h0201);
    check_flags("ld0_nopop", 1'b0, 1'b0, 1'b0);
    // Reset together with a pop request on a non-empty stack.
    @(negedge Clk);
    LD_PC = 1'b1; PCMUX = 2'b11; Push = 1'b1; Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("reset_dom", dataOut, 16'h0200);
    check_flags("reset_dom", 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0; LD_PC = 1'b0; Push = 1'b0;
`else
    step(1, 2'b01, 1, 16'h0, 16'h5555); check("nopush_jump", dataOut, 16'h5555);
    step(1, 2'b11, 0, 16'h0, 16'h0);    check("nopop_hold", dataOut, 16'h5555);
    check_flags("noras", 1'b1, 1'b0, 1'b0);
    step(1, 2'b11, 1, 16'h0, 16'h0);    check("nopop_hold2", dataOut, 16'h5555);
    check_flags("noras2", 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    LD_PC = 1'b1; PCMUX = 2'b11; Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("reset_dom", dataOut, 16'h0200);
    @(negedge Clk);
    Reset = 1'b0; LD_PC = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
